// File: rtl/uart_pkg.sv
// Shared definitions for the player-sync UART link.
// Both the sender (player_state_uart_tx) and the receiver build packet bytes
// through pkt_byte so that the two ends cannot drift apart on the layout.
package uart_pkg;

  typedef enum logic {TX_IDLE, TX_SEND} ptx_state_t;

  localparam int         PKT_LEN  = 6;
  localparam logic [7:0] PKT_SYNC = 8'hA5;

  // Byte idx of the packet for a given snapshot.
  // Index 5 is the XOR of the four payload bytes.
  // Any index past the end of the packet returns 0.
  function automatic logic [7:0] pkt_byte(input logic [2:0]  idx,
                                          input logic [11:0] x,
                                          input logic [11:0] y,
                                          input logic [1:0]  lvl);
    logic [7:0] b1, b2, b3, b4;
    b1 = x[11:4];
    b2 = {x[3:0], y[11:8]};
    b3 = y[7:0];
    b4 = {6'b0, lvl};
    case (idx)
      3'd0:    pkt_byte = PKT_SYNC;
      3'd1:    pkt_byte = b1;
      3'd2:    pkt_byte = b2;
      3'd3:    pkt_byte = b3;
      3'd4:    pkt_byte = b4;
      3'd5:    pkt_byte = b1 ^ b2 ^ b3 ^ b4;
      default: pkt_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/player_state_uart_tx.sv
// Sender side of the player-sync link.
// Once every FRAME_DIV frame ticks it snapshots the local player's x/y/level.
// It then streams the result as a 6-byte packet over a valid/ready byte interface:
//   SYNC, x[11:4], {x[3:0],y[11:8]}, y[7:0], {6'b0,level}, XOR checksum.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   frame_tick        1-cycle pulse per frame
//   x_value, y_value  12-bit local player position
//   level_home        2-bit local player level
//   tx_data/tx_valid  byte stream to the UART serialiser, held until tx_ready
//   tx_ready          serialiser accepts the byte when tx_valid && tx_ready
//   busy              high while a packet is in flight
//   pkt_sent          1-cycle pulse after the checksum byte is accepted
//   tick_dropped      1-cycle pulse (registered) for a frame_tick seen while busy
module player_state_uart_tx
  import uart_pkg::*;
#(
  parameter int         FRAME_DIV = 1,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [11:0] x_value,
  input  logic [11:0] y_value,
  input  logic [1:0]  level_home,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        pkt_sent,
  output logic        tick_dropped
);

  localparam logic [3:0] DIV_LAST  = 4'(FRAME_DIV - 1);
  localparam logic [2:0] BYTE_LAST = 3'(PKT_LEN - 1);

  ptx_state_t  state;
  logic [3:0]  div_cnt;
  logic [2:0]  byte_idx;
  logic [11:0] snap_x, snap_y;
  logic [1:0]  snap_lvl;
  logic [7:0]  cks_q;
  logic [7:0]  next_byte;

  // Payload bytes come from the frozen snapshot.
  // Input changes during SEND are therefore invisible to the packet.
  // The checksum is taken from the registered copy captured at latch time.
  always_comb begin
    next_byte = pkt_byte(byte_idx + 3'd1, snap_x, snap_y, snap_lvl);
    if (byte_idx == BYTE_LAST - 3'd1) next_byte = cks_q;
  end

  assign busy = (state == TX_SEND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= TX_IDLE;
      div_cnt      <= '0;
      byte_idx     <= '0;
      snap_x       <= '0;
      snap_y       <= '0;
      snap_lvl     <= '0;
      cks_q        <= '0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      pkt_sent     <= 1'b0;
      tick_dropped <= 1'b0;
    end else begin
      pkt_sent     <= 1'b0;
      tick_dropped <= 1'b0;
      case (state)
        TX_IDLE: begin
          if (frame_tick) begin
            if (div_cnt == DIV_LAST) begin
              snap_x   <= x_value;
              snap_y   <= y_value;
              snap_lvl <= level_home;
              cks_q    <= pkt_byte(3'd5, x_value, y_value, level_home);
              div_cnt  <= '0;
              byte_idx <= '0;
              tx_data  <= SYNC_BYTE;
              tx_valid <= 1'b1;
              state    <= TX_SEND;
            end else begin
              div_cnt <= div_cnt + 4'd1;
            end
          end
        end
        TX_SEND: begin
          // A tick that arrives while sending is dropped, including one that
          // lands on the same cycle as the checksum handshake.
          tick_dropped <= frame_tick;
          // tx_valid is constantly 1 in SEND, so tx_ready alone is the handshake.
          if (tx_ready) begin
            if (byte_idx == BYTE_LAST) begin
              state    <= TX_IDLE;
              byte_idx <= '0;
              tx_valid <= 1'b0;
              tx_data  <= '0;
              pkt_sent <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              tx_data  <= next_byte;
            end
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_player_state_uart_tx.sv
// Self-checking bench for player_state_uart_tx.
// dut  runs with FRAME_DIV=1.
// dut3 runs with FRAME_DIV=3 and covers the divider and tick-drop behaviour.
module tb_player_state_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick, frame_tick3;
  logic [11:0] x_value, y_value;
  logic [1:0]  level_home;
  logic        tx_ready, tx_ready3;
  logic [7:0]  tx_data, tx_data3;
  logic        tx_valid, tx_valid3, busy, busy3;
  logic        pkt_sent, pkt_sent3, tick_dropped, tick_dropped3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  player_state_uart_tx #(.FRAME_DIV(1), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .x_value(x_value), .y_value(y_value), .level_home(level_home),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .pkt_sent(pkt_sent), .tick_dropped(tick_dropped));

  player_state_uart_tx #(.FRAME_DIV(3), .SYNC_BYTE(8'hA5)) dut3 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick3),
    .x_value(x_value), .y_value(y_value), .level_home(level_home),
    .tx_data(tx_data3), .tx_valid(tx_valid3), .tx_ready(tx_ready3),
    .busy(busy3), .pkt_sent(pkt_sent3), .tick_dropped(tick_dropped3));

  // Each record holds the inputs and the expected bytes.
  // exp[k] is packet byte k.
  typedef struct {
    logic [11:0]     x;
    logic [11:0]     y;
    logic [1:0]      lvl;
    logic [5:0][7:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fire(input logic [11:0] x, input logic [11:0] y, input logic [1:0] l);
    x_value    = x;
    y_value    = y;
    level_home = l;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  // Walk one packet through the handshake.
  // stall      : drive tx_ready pseudo-randomly instead of holding it high.
  // mut_at     : cycle at which x_value is overwritten with mut_x (-1 = never).
  // tick_last  : raise frame_tick on the cycle the checksum byte is accepted.
  task automatic run_pkt(input string tag, input logic [5:0][7:0] e, input bit stall,
                         input int mut_at, input logic [11:0] mut_x, input bit tick_last);
    int  k   = 0;
    int  cyc = 0;
    logic r;
    while (k < 6 && cyc < 200) begin
      r = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      tx_ready = r;
      if (tick_last && k == 5) frame_tick = 1'b1;
      if (cyc == mut_at) x_value = mut_x;
      check({tag, " valid"}, {31'd0, tx_valid}, 32'd1);
      check({tag, " data"}, {24'd0, tx_data}, {24'd0, e[k]});
      check({tag, " busy"}, {31'd0, busy}, 32'd1);
      step();
      frame_tick = 1'b0;
      if (r) k++;
      cyc++;
    end
    check({tag, " bytes done"}, k, 6);
    tx_ready = 1'b1;
    check({tag, " end valid"}, {31'd0, tx_valid}, 32'd0);
    check({tag, " end busy"}, {31'd0, busy}, 32'd0);
    check({tag, " pkt_sent"}, {31'd0, pkt_sent}, 32'd1);
    if (tick_last) check({tag, " drop at end"}, {31'd0, tick_dropped}, 32'd1);
    step();
    check({tag, " pkt_sent pulse"}, {31'd0, pkt_sent}, 32'd0);
    check({tag, " stays idle"}, {31'd0, tx_valid}, 32'd0);
  endtask

  initial begin
    int starts, drops, start_c;
    logic pb;

    vecs[0] = '{x: 12'h123, y: 12'h0F0, lvl: 2'd2, exp: {8'hD0, 8'h02, 8'hF0, 8'h30, 8'h12, 8'hA5}};
    vecs[1] = '{x: 12'hFFF, y: 12'hFFF, lvl: 2'd3, exp: {8'hFC, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hA5}};
    vecs[2] = '{x: 12'hA5A, y: 12'h5A5, lvl: 2'd0, exp: {8'hA5, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5}};
    vecs[3] = '{x: 12'h000, y: 12'h000, lvl: 2'd0, exp: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5}};
    vecs[4] = '{x: 12'h456, y: 12'h789, lvl: 2'd1, exp: {8'hAA, 8'h01, 8'h89, 8'h67, 8'h45, 8'hA5}};

    rst = 1'b1;
    frame_tick = 1'b0; frame_tick3 = 1'b0;
    x_value = '0; y_value = '0; level_home = '0;
    tx_ready = 1'b1; tx_ready3 = 1'b0;
    step();
    check("rst tx_data", {24'd0, tx_data}, 32'd0);
    check("rst tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst pkt_sent", {31'd0, pkt_sent}, 32'd0);
    check("rst tick_dropped", {31'd0, tick_dropped}, 32'd0);
    check("rst busy3", {31'd0, busy3}, 32'd0);
    rst = 1'b0;
    step();

    // Table-driven packets, back-to-back ready.
    foreach (vecs[i]) begin
      fire(vecs[i].x, vecs[i].y, vecs[i].lvl);
      run_pkt($sformatf("vec%0d", i), vecs[i].exp, 1'b0, -1, 12'h0, 1'b0);
    end

    // Backpressure: same bytes with random stalls, held stable while stalled.
    fire(12'h123, 12'h0F0, 2'd2);
    run_pkt("bp", vecs[0].exp, 1'b1, -1, 12'h0, 1'b0);

    // Snapshot coherency: x changes mid-packet; the next packet picks it up.
    fire(12'h123, 12'h0F0, 2'd2);
    run_pkt("snap1", vecs[0].exp, 1'b0, 2, 12'hFFF, 1'b0);
    fire(12'hFFF, 12'h0F0, 2'd2);
    run_pkt("snap2", {8'hFD, 8'h02, 8'hF0, 8'hF0, 8'hFF, 8'hA5}, 1'b0, -1, 12'h0, 1'b0);

    // frame_tick on the checksum handshake is dropped; no new packet follows.
    fire(12'h456, 12'h789, 2'd1);
    run_pkt("tick_last", vecs[4].exp, 1'b0, -1, 12'h0, 1'b1);

    // Divider and drops: FRAME_DIV=3, tick every 4 cycles, serialiser stalled.
    starts = 0; drops = 0; start_c = -1; pb = 1'b0;
    for (int c = 0; c < 40; c++) begin
      frame_tick3 = (c % 4 == 0);
      step();
      frame_tick3 = 1'b0;
      if (busy3 && !pb) begin
        starts++;
        start_c = c;
      end
      pb = busy3;
      if (tick_dropped3) drops++;
    end
    check("div starts", starts, 1);
    check("div start tick", start_c, 8);
    check("div drops", drops, 7);
    check("div held data", {24'd0, tx_data3}, 32'h0000_00A5);
    check("div held valid", {31'd0, tx_valid3}, 32'd1);

    // Reset mid-packet, after B2 has been accepted.
    fire(12'h123, 12'h0F0, 2'd2);
    tx_ready = 1'b1;
    step(); step(); step();
    check("pre-rst data B3", {24'd0, tx_data}, 32'h0000_00F0);
    rst = 1'b1;
    #1;
    check("mid rst valid", {31'd0, tx_valid}, 32'd0);
    check("mid rst busy", {31'd0, busy}, 32'd0);
    check("mid rst data", {24'd0, tx_data}, 32'd0);
    step();
    rst = 1'b0;
    step();
    check("post rst idle", {31'd0, tx_valid}, 32'd0);
    fire(12'h456, 12'h789, 2'd1);
    run_pkt("post_rst", vecs[4].exp, 1'b0, -1, 12'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
